// File: rtl/expr_eval.sv
// Streaming ASCII expression evaluator for '+', '-' and '*' over multi-digit decimal operands.
// Consumes one character per in_valid cycle. All outputs are registered, one cycle after acceptance.
module expr_eval #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned MAX_DIGITS = 5
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             in_valid,
    input  logic [7:0]       in,
    output logic             out,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             error,
    output logic [1:0]       status
);

    localparam int unsigned DW = $clog2(MAX_DIGITS + 1);
    localparam logic [DW-1:0]    MAXD = DW'(MAX_DIGITS);
    localparam logic [WIDTH-1:0] TEN  = WIDTH'(10);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StNum  = 2'd1,
        StOp   = 2'd2,
        StErr  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] term_q, term_d;
    logic [WIDTH-1:0] num_q, num_d;
    logic             neg_q, neg_d;
    logic [DW-1:0]    dcnt_q, dcnt_d;
    logic             out_q, out_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    logic             is_digit, is_addsub, is_mul, is_semi;
    logic [WIDTH-1:0] digit;
    logic [WIDTH-1:0] cur_prod, cur_signed, next_prod;
    logic             upd, go_err;

    assign is_digit  = (in >= 8'h30) && (in <= 8'h39);
    assign is_addsub = (in == 8'h2b) || (in == 8'h2d);
    assign is_mul    = (in == 8'h2a);
    assign is_semi   = (in == 8'h3b);
    assign digit     = {{(WIDTH-4){1'b0}}, in[3:0]};

    // Signed contribution of the term in progress, folded into sum on '+'/'-'.
    assign cur_prod   = term_q * num_q;
    assign cur_signed = neg_q ? (~cur_prod + ONE) : cur_prod;

    always_comb begin
        state_d  = state_q;
        sum_d    = sum_q;
        term_d   = term_q;
        num_d    = num_q;
        neg_d    = neg_q;
        dcnt_d   = dcnt_q;
        out_d    = out_q;
        result_d = result_q;
        done_d   = 1'b0;
        error_d  = error_q;
        upd      = 1'b0;
        go_err   = 1'b0;
        next_prod = '0;

        if (in_valid) begin
            unique case (state_q)
                StIdle: begin
                    if (is_digit) begin
                        state_d = StNum;
                        num_d   = digit;
                        dcnt_d  = DW'(1);
                        upd     = 1'b1;
                    end else if (is_semi) begin
                        out_d = 1'b0;
                    end else begin
                        go_err = 1'b1;
                    end
                end
                StNum: begin
                    if (is_digit) begin
                        if (dcnt_q == MAXD) begin
                            go_err = 1'b1;
                        end else begin
                            num_d  = num_q * TEN + digit;
                            dcnt_d = dcnt_q + DW'(1);
                            upd    = 1'b1;
                        end
                    end else if (is_addsub) begin
                        state_d = StOp;
                        sum_d   = sum_q + cur_signed;
                        term_d  = ONE;
                        num_d   = '0;
                        dcnt_d  = '0;
                        neg_d   = (in == 8'h2d);
                        out_d   = 1'b0;
                    end else if (is_mul) begin
                        state_d = StOp;
                        term_d  = cur_prod;
                        num_d   = '0;
                        dcnt_d  = '0;
                        out_d   = 1'b0;
                    end else if (is_semi) begin
                        // result/out already hold the final value; only the accumulators restart.
                        state_d = StIdle;
                        done_d  = 1'b1;
                        sum_d   = '0;
                        term_d  = ONE;
                        num_d   = '0;
                        neg_d   = 1'b0;
                        dcnt_d  = '0;
                    end else begin
                        go_err = 1'b1;
                    end
                end
                StOp: begin
                    if (is_digit) begin
                        state_d = StNum;
                        num_d   = digit;
                        dcnt_d  = DW'(1);
                        upd     = 1'b1;
                    end else begin
                        go_err = 1'b1;
                    end
                end
                StErr: begin
                end
            endcase
        end

        if (upd) begin
            next_prod = term_d * num_d;
            out_d     = 1'b1;
            result_d  = neg_d ? (sum_d - next_prod) : (sum_d + next_prod);
        end

        if (go_err) begin
            state_d  = StErr;
            out_d    = 1'b0;
            result_d = '0;
            error_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q  <= StIdle;
            sum_q    <= '0;
            term_q   <= ONE;
            num_q    <= '0;
            neg_q    <= 1'b0;
            dcnt_q   <= '0;
            out_q    <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sum_q    <= sum_d;
            term_q   <= term_d;
            num_q    <= num_d;
            neg_q    <= neg_d;
            dcnt_q   <= dcnt_d;
            out_q    <= out_d;
            result_q <= result_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    assign out    = out_q;
    assign result = result_q;
    assign done   = done_q;
    assign error  = error_q;
    assign status = state_q;

endmodule

// File: tb/tb_expr_eval.sv
// Scoreboard bench for expr_eval: a string-based expression model predicts every cycle's outputs.
// Directed cases from the block description are followed by a long randomized run.
module tb_expr_eval;

    localparam int unsigned WIDTH      = 16;
    localparam int unsigned MAX_DIGITS = 5;

    logic             clk = 1'b0;
    logic             clr_n = 1'b0;
    logic             in_valid = 1'b0;
    logic [7:0]       in_ch = 8'h00;
    logic             out;
    logic [WIDTH-1:0] result;
    logic             done;
    logic             error;
    logic [1:0]       status;

    expr_eval #(.WIDTH(WIDTH), .MAX_DIGITS(MAX_DIGITS)) dut (
        .clk     (clk),
        .clr_n   (clr_n),
        .in_valid(in_valid),
        .in      (in_ch),
        .out     (out),
        .result  (result),
        .done    (done),
        .error   (error),
        .status  (status)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             o;
        logic [WIDTH-1:0] r;
        logic             d;
        logic             e;
        logic [1:0]       s;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Model state: the accepted characters since the last reset or completed expression.
    string            m_expr;
    bit               m_err;
    bit               m_out;
    logic [WIDTH-1:0] m_res;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic bit is_dig(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    function automatic int trail_digits(input string e);
        int n = 0;
        for (int i = e.len() - 1; i >= 0; i--) begin
            if (!is_dig(e[i])) break;
            n++;
        end
        return n;
    endfunction

    // Sum of signed products; 64-bit wrap is harmless since only the low WIDTH bits are kept.
    function automatic logic [WIDTH-1:0] eval_expr(input string e);
        longint total = 0;
        longint prod  = 1;
        longint num   = 0;
        longint sgn   = 1;
        for (int i = 0; i < e.len(); i++) begin
            logic [7:0] c;
            c = e[i];
            if (is_dig(c)) begin
                num = num * 10 + longint'(c - 8'h30);
            end else if (c == "*") begin
                prod = prod * num;
                num  = 0;
            end else begin
                total = total + sgn * prod * num;
                prod  = 1;
                num   = 0;
                sgn   = (c == "-") ? -1 : 1;
            end
        end
        total = total + sgn * prod * num;
        return total[WIDTH-1:0];
    endfunction

    function automatic exp_t model_view(input bit d);
        exp_t x;
        x.d = d;
        x.e = m_err;
        if (m_err) begin
            x.o = 1'b0;
            x.r = '0;
            x.s = 2'd3;
        end else begin
            x.o = m_out;
            x.r = m_res;
            if (m_expr.len() == 0)                      x.s = 2'd0;
            else if (is_dig(m_expr[m_expr.len() - 1])) x.s = 2'd1;
            else                                        x.s = 2'd2;
        end
        return x;
    endfunction

    task automatic model_apply(input bit v, input logic [7:0] c, output exp_t x);
        bit d = 1'b0;
        if (v && !m_err) begin
            if (is_dig(c)) begin
                m_expr = $sformatf("%s%c", m_expr, c);
                if (trail_digits(m_expr) > MAX_DIGITS) begin
                    m_err = 1'b1;
                end else begin
                    m_out = 1'b1;
                    m_res = eval_expr(m_expr);
                end
            end else if (c == "+" || c == "-" || c == "*") begin
                if (m_expr.len() == 0 || !is_dig(m_expr[m_expr.len() - 1])) m_err = 1'b1;
                else begin
                    m_expr = $sformatf("%s%c", m_expr, c);
                    m_out  = 1'b0;
                end
            end else if (c == ";") begin
                if (m_expr.len() == 0) m_out = 1'b0;
                else if (is_dig(m_expr[m_expr.len() - 1])) begin
                    d      = 1'b1;
                    m_expr = "";
                end else m_err = 1'b1;
            end else begin
                m_err = 1'b1;
            end
        end
        x = model_view(d);
    endtask

    task automatic step(input bit v, input logic [7:0] c);
        exp_t x;
        @(negedge clk);
        in_valid = v;
        in_ch    = c;
        model_apply(v, c, x);
        q.push_back(x);
    endtask

    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) step(1'b1, s[i]);
    endtask

    // One idle cycle, then a direct check of the held outputs against fixed values.
    task automatic hold_check(input string name, input logic o, input logic [WIDTH-1:0] r,
                              input logic e, input logic [1:0] s);
        step(1'b0, 8'h00);
        @(posedge clk);
        #2;
        chk({name, ".out"}, 32'(out), 32'(o));
        chk({name, ".result"}, 32'(result), 32'(r));
        chk({name, ".error"}, 32'(error), 32'(e));
        chk({name, ".status"}, 32'(status), 32'(s));
    endtask

    task automatic do_reset();
        exp_t x;
        @(negedge clk);
        in_valid = 1'b0;
        clr_n    = 1'b0;
        #1;
        chk("async_rst.status", 32'(status), 32'd0);
        chk("async_rst.result", 32'(result), 32'd0);
        chk("async_rst.error", 32'(error), 32'd0);
        m_expr = "";
        m_err  = 1'b0;
        m_out  = 1'b0;
        m_res  = '0;
        x = model_view(1'b0);
        q.push_back(x);
        @(negedge clk);
        clr_n = 1'b1;
    endtask

    function automatic logic [7:0] rand_char();
        int r;
        logic [7:0] ill [5];
        ill = '{8'h61, 8'h20, 8'h2f, 8'h28, 8'h3d};
        r = $urandom_range(0, 99);
        if (r < 55) return 8'h30 + 8'($urandom_range(0, 9));
        if (r < 63) return 8'h2b;
        if (r < 70) return 8'h2d;
        if (r < 78) return 8'h2a;
        if (r < 96) return 8'h3b;
        return ill[$urandom_range(0, 4)];
    endfunction

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            if (q.size() > 0) begin
                x = q.pop_front();
                #1;
                chk("sb.out", 32'(out), 32'(x.o));
                chk("sb.result", 32'(result), 32'(x.r));
                chk("sb.done", 32'(done), 32'(x.d));
                chk("sb.error", 32'(error), 32'(x.e));
                chk("sb.status", 32'(status), 32'(x.s));
            end
        end
    end

    initial begin : driver
        int drain;
        m_expr = "";
        m_err  = 1'b0;
        m_out  = 1'b0;
        m_res  = '0;
        do_reset();

        send("1+2*3;");
        hold_check("prec", 1'b1, 16'd7, 1'b0, 2'd0);

        send("12*3-40;");
        hold_check("neg", 1'b1, 16'hFFFC, 1'b0, 2'd0);

        send("1++");
        hold_check("dblop", 1'b0, 16'd0, 1'b1, 2'd3);
        send("2;");
        hold_check("sticky", 1'b0, 16'd0, 1'b1, 2'd3);
        do_reset();

        send("99999");
        hold_check("maxdig", 1'b1, 16'h869F, 1'b0, 2'd1);
        send("9");
        hold_check("overdig", 1'b0, 16'd0, 1'b1, 2'd3);
        do_reset();

        send("3*");
        repeat (3) step(1'b0, 8'h34);
        send("4");
        repeat (2) step(1'b0, 8'h3b);
        hold_check("gaps", 1'b1, 16'd12, 1'b0, 2'd1);
        send(";");

        send("5*");
        do_reset();
        send("2;");
        hold_check("rst_mid", 1'b1, 16'd2, 1'b0, 2'd0);

        send("007+1;;");
        hold_check("lead0", 1'b0, 16'd8, 1'b0, 2'd0);

        for (int i = 0; i < 4000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2 || (m_err && r < 30)) do_reset();
            else if (r < 12) step(1'b0, rand_char());
            else step(1'b1, rand_char());
        end

        drain = 0;
        while (q.size() > 0 && drain < 20) begin
            @(posedge clk);
            drain++;
        end
        if (q.size() > 0) chk("drain", 32'(q.size()), 32'd0);
        @(posedge clk);
        #3;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
